// File: rtl/scanner_pkg.sv
// Shared types and constants for the set-bit scanner.
package scanner_pkg;

    // Default datapath word width.
    localparam int unsigned DefaultWidth = 32;

    // Index width for a given word width; never below one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned DefaultIdxW = idx_width(DefaultWidth);

    // Scanner FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StEmpty = 2'd2
    } state_e;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational lowest-set-bit finder: index, presence flag and a one-hot
// mask of that bit so the caller can clear it.
module lowest_set_bit
    import scanner_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] index_o,
    output logic             found_o,
    output logic [WIDTH-1:0] one_hot_clear_o
);

    logic [WIDTH-1:0] one_hot;

    // Isolate the lowest set bit (two's complement trick), then encode it.
    always_comb begin
        one_hot = vec_i & (~vec_i + WIDTH'(1));
        index_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (one_hot[i]) begin
                index_o = index_o | IDX_W'(i);
            end
        end
        found_o         = |vec_i;
        one_hot_clear_o = one_hot;
    end

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts one word over valid/ready and streams out the index of each set
// bit, lowest first; an all-zero word yields a single flagged empty beat.
module set_bit_scanner
    import scanner_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_empty,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [IDX_W-1:0] lsb_index;
    logic             lsb_found;
    logic [WIDTH-1:0] lsb_clear;
    logic             single_bit;

    lowest_set_bit #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb (
        .vec_i           (rem_q),
        .index_o         (lsb_index),
        .found_o         (lsb_found),
        .one_hot_clear_o (lsb_clear)
    );

    // Exactly one bit remaining means the current beat is the last one.
    always_comb begin
        single_bit = lsb_found && ((rem_q & (rem_q - WIDTH'(1))) == '0);
    end

    // Next-state, rem update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_index = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // Held low during reset so nothing is taken while flops clear.
                in_ready = !reset;
                if (in_valid && in_ready) begin
                    if (in_data == '0) begin
                        rem_d   = '0;
                        state_d = StEmpty;
                    end else begin
                        rem_d   = in_data;
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                out_valid = 1'b1;
                out_index = lsb_index;
                out_last  = single_bit;
                if (!lsb_found) begin
                    // Unreachable in normal operation; recover rather than hang.
                    state_d = StIdle;
                end else if (out_ready) begin
                    rem_d = rem_q & ~lsb_clear;
                    if (single_bit) begin
                        state_d = StIdle;
                    end
                end
            end
            StEmpty: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_empty = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                rem_d   = '0;
            end
        endcase
    end

    // State and remaining-bits registers; reset discards any word in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule
